dft_stream_rx: RTL and testbench
================================

DFT_STREAM_RX -- requirements
Module: dft_stream_rx

Interface
REQ-001 Parameter IN_W, default 30, input sample width per component (real/imag).
REQ-002 Parameter OUT_W, default 18, output sample width per component.
REQ-003 Parameter SHIFT, default 12, arithmetic right-shift applied before narrowing.
REQ-004 Parameter DEPTH, default 4, output FIFO depth in beats; power of two, 2..16.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 s_valid/s_sop/s_eop  in  1 each  DFT source-side beat qualifiers.
REQ-008 s_real/s_imag  in  IN_W each  signed DFT output sample.
REQ-009 s_ready  out  1  upstream backpressure; a beat transfers when s_valid && s_ready.
REQ-010 dftpts  in  12  expected frame length (12..1200); sampled on each accepted sop beat.
REQ-011 m_valid/m_sop/m_eop  out  1 each; m_real/m_imag  out  OUT_W each  narrowed output stream.
REQ-012 m_ready  in  1  downstream accept; a beat leaves when m_valid && m_ready.
REQ-013 frame_ok/err_nosop/err_len/err_sop  out  1 each  single-cycle status pulses.
REQ-014 frame_cnt  out  16  count of frames ending with frame_ok, wraps 0xFFFF->0.

Function
REQ-015 FSM states IDLE and IN_FRAME; only accepted beats advance it.
REQ-016 IDLE + accepted sop: latch len=dftpts, beat index idx=0, push beat, go IN_FRAME; if eop also set and len==1, pulse frame_ok, stay IDLE.
REQ-017 IDLE + accepted beat without sop: drop beat (no push), pulse err_nosop.
REQ-018 IN_FRAME + accepted beat: idx++, push beat.
REQ-019 IN_FRAME, eop with idx==len-1: pulse frame_ok, frame_cnt++, go IDLE.
REQ-020 IN_FRAME, eop with idx!=len-1: pulse err_len, go IDLE; beat still pushed with m_eop=1.
REQ-021 IN_FRAME, idx reaches len-1 without eop: pulse err_len, force m_eop=1 on that beat, go IDLE (later beats of that frame drop via REQ-017).
REQ-022 IN_FRAME + accepted sop: pulse err_sop, restart frame per REQ-016 (new len, idx=0).
REQ-023 Narrowing: value = sample >>> SHIFT (arithmetic), then saturate to signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-024 Narrowing, flags and FSM update are combinational on the input beat; pushed entry appears at m_* one cycle after acceptance when FIFO was empty (latency 1).
REQ-025 FIFO holds {sop,eop,real,imag}; s_ready = (occupancy < DEPTH), registered, so s_ready low when full; simultaneous push and pop keep occupancy unchanged.
REQ-026 m_valid = occupancy != 0; m_* stable while m_valid && !m_ready.
REQ-027 Pulse outputs are registered and high exactly one cycle per event.

Reset
REQ-028 While rst_n==0 at a rising edge: FSM=IDLE, idx=0, len=0, FIFO empty, frame_cnt=0, all pulses 0, m_valid=0, m_sop=m_eop=0, m_real=m_imag=0, s_ready=0.
REQ-029 First cycle after reset release: s_ready=1; reset mid-frame discards FIFO contents and partial frame with no error pulse.

Configuration
REQ-030 With DFT_RX_ROUND_EN defined: add 2^(SHIFT-1) to the IN_W+1-bit sign-extended sample before the shift (round half up); without it: plain truncating shift; saturation identical in both builds.

Structure
REQ-031 Package dft_rx_pkg holds the FSM state enum, the FIFO entry struct, and constant MAX_DFTPTS=1200.
REQ-032 One sub-module, dft_rx_fifo (parameterised width/DEPTH, registered full/empty); FSM and narrowing live in dft_stream_rx.

Verification
REQ-033 dftpts=12, 12 beats sop..eop, m_ready=1 -> 12 output beats, m_sop on first, m_eop on twelfth, one frame_ok, frame_cnt=1.
REQ-034 s_real=0x0001FFF (truncating build, SHIFT=12) -> m_real=1; rounding build -> m_real=2; s_real=0x1FFFFFFF -> m_real=131071 (saturated).
REQ-035 dftpts=24, eop on beat 20 -> err_len pulse, m_eop on beat 20, frame_cnt unchanged; next sop frame of 24 -> frame_ok.
REQ-036 m_ready=0 for 10 cycles with DEPTH=4, s_valid=1 -> s_ready falls after 4 accepted beats; release -> all beats delivered in order, none lost or duplicated.
REQ-037 Beat without sop in IDLE -> err_nosop pulse, no output beat; sop at idx 5 of a 12-point frame -> err_sop, new frame completes with frame_ok.
REQ-038 rst_n low for one cycle at idx 6 of a 12-point frame -> FIFO empty, m_valid=0 next cycle, no error pulses, following frame correct.

Source files
------------

// File: rtl/dft_rx_pkg.sv
// dft_rx_pkg -- shared types and constants for the DFT output stream receiver.
//
// Contents:
//   MAX_DFTPTS  largest supported frame length
//   DFTPTS_W    width of the dftpts frame-length input
//   IDX_W       width of the in-frame beat index
//   rx_state_e  framing FSM state
//   fifo_tag_t  framing bits of a FIFO entry. The complete entry is
//               {fifo_tag_t, real[OUT_W-1:0], imag[OUT_W-1:0]}. The sample
//               fields depend on OUT_W, so they are appended by the
//               parameterised top rather than fixed here.
package dft_rx_pkg;

  localparam int MAX_DFTPTS = 1200;
  localparam int DFTPTS_W   = 12;
  localparam int IDX_W      = $clog2(MAX_DFTPTS);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } rx_state_e;

  typedef struct packed {
    logic sop;
    logic eop;
  } fifo_tag_t;

endpackage

// File: rtl/dft_rx_fifo.sv
// dft_rx_fifo -- small synchronous FIFO with registered flags.
//
// Parameters: WIDTH entry width, DEPTH entries (power of two).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   push, push_data     write request; it is ignored while not_full is low
//   pop                 read request; it is ignored while empty is high
//   pop_data            head entry, forced to zero while the FIFO is empty
//   not_full            registered; low during reset and when DEPTH entries are held
//   empty               registered; high during reset
module dft_rx_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             not_full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             not_full_q, not_full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  assign do_push = push && not_full_q;
  assign do_pop  = pop && !empty_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(do_push);
    rd_ptr_d   = rd_ptr_q + AW'(do_pop);
    count_d    = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    not_full_d = (count_d < DEPTH_C);
    empty_d    = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      not_full_q <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      not_full_q <= not_full_d;
      empty_q    <= empty_d;
    end
  end

  // Storage needs no reset: the read port is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = empty_q ? '0 : mem_q[rd_ptr_q];
  assign not_full = not_full_q;
  assign empty    = empty_q;

endmodule

// File: rtl/dft_stream_rx.sv
// dft_stream_rx -- receives the DFT output stream, checks the frame structure
// against the expected length, narrows each sample and buffers the beats for
// the downstream consumer.
//
// Build option: DFT_RX_ROUND_EN adds a round-half-up step before the shift.
// Without it, the shift truncates. Saturation is the same in both builds.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   s_valid/s_sop/s_eop/s_real/s_imag input beat; s_ready is the registered FIFO space
//   dftpts                           expected frame length, taken on each accepted sop
//   m_valid/m_sop/m_eop/m_real/m_imag narrowed output beat; m_ready is the downstream accept
//   frame_ok/err_nosop/err_len/err_sop one-cycle registered status pulses
//   frame_cnt                        number of frames that completed with frame_ok
//   dbg_state                        framing FSM state
//
// Handshake: a beat moves on a rising edge where valid && ready. An output
// beat stays stable while m_valid && !m_ready.
module dft_stream_rx
  import dft_rx_pkg::*;
#(
  parameter int IN_W  = 30,
  parameter int OUT_W = 18,
  parameter int SHIFT = 12,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  input  logic                    s_sop,
  input  logic                    s_eop,
  input  logic signed [IN_W-1:0]  s_real,
  input  logic signed [IN_W-1:0]  s_imag,
  output logic                    s_ready,
  input  logic [DFTPTS_W-1:0]     dftpts,
  output logic                    m_valid,
  output logic                    m_sop,
  output logic                    m_eop,
  output logic signed [OUT_W-1:0] m_real,
  output logic signed [OUT_W-1:0] m_imag,
  input  logic                    m_ready,
  output logic                    frame_ok,
  output logic                    err_nosop,
  output logic                    err_len,
  output logic                    err_sop,
  output logic [15:0]             frame_cnt,
  output rx_state_e               dbg_state
);

  localparam int ENTRY_W = 2 + 2*OUT_W;
  localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
`ifdef DFT_RX_ROUND_EN
  localparam logic signed [IN_W:0] RND = (IN_W+1)'(1) << (SHIFT-1);
`endif

  // The extra bit lets the rounding offset be added without overflow.
  function automatic logic [OUT_W-1:0] narrow(input logic [IN_W-1:0] s);
    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] shr;
    ext = $signed({s[IN_W-1], s});
`ifdef DFT_RX_ROUND_EN
    ext = ext + RND;
`endif
    shr = ext >>> SHIFT;
    if (shr > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
    else if (shr < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    else                    return shr[OUT_W-1:0];
  endfunction

  rx_state_e            state_q, state_d;
  logic [DFTPTS_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic                 frame_ok_q, frame_ok_d;
  logic                 err_nosop_q, err_nosop_d;
  logic                 err_len_q, err_len_d;
  logic                 err_sop_q, err_sop_d;

  logic                 accept;
  logic                 push;
  fifo_tag_t            tag;
  logic [DFTPTS_W-1:0]  cur_len, cur_idx;
  logic                 last;
  logic [ENTRY_W-1:0]   push_data, pop_data;
  logic                 fifo_not_full, fifo_empty;

  assign accept = s_valid && s_ready;

  // Length and index of the beat being accepted. A sop always starts a new
  // frame at index 0, whether the FSM was idle or inside a frame.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    frame_ok_d  = 1'b0;
    err_nosop_d = 1'b0;
    err_len_d   = 1'b0;
    err_sop_d   = 1'b0;
    push        = 1'b0;
    tag.sop     = s_sop;
    tag.eop     = s_eop;
    cur_len     = len_q;
    cur_idx     = DFTPTS_W'(idx_q) + DFTPTS_W'(1);
    last        = 1'b0;
    if (accept) begin
      if (s_sop) begin
        err_sop_d = (state_q == ST_IN_FRAME);
        cur_len   = dftpts;
        cur_idx   = '0;
      end
      if (s_sop || state_q == ST_IN_FRAME) begin
        push    = 1'b1;
        len_d   = cur_len;
        idx_d   = cur_idx[IDX_W-1:0];
        last    = (cur_idx == cur_len - DFTPTS_W'(1));
        state_d = ST_IN_FRAME;
        if (s_eop && last) begin
          frame_ok_d  = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_IDLE;
        end else if (s_eop) begin
          err_len_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (last) begin
          // The frame is closed here. Any further beats are dropped as sop-less.
          err_len_d = 1'b1;
          tag.eop   = 1'b1;
          state_d   = ST_IDLE;
        end
      end else begin
        err_nosop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      frame_ok_q  <= 1'b0;
      err_nosop_q <= 1'b0;
      err_len_q   <= 1'b0;
      err_sop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      frame_ok_q  <= frame_ok_d;
      err_nosop_q <= err_nosop_d;
      err_len_q   <= err_len_d;
      err_sop_q   <= err_sop_d;
    end
  end

  assign push_data = {tag, narrow(s_real), narrow(s_imag)};

  dft_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (m_ready),
    .pop_data  (pop_data),
    .not_full  (fifo_not_full),
    .empty     (fifo_empty)
  );

  assign s_ready = fifo_not_full;
  assign m_valid = !fifo_empty;
  assign {m_sop, m_eop, m_real, m_imag} = pop_data;

  assign frame_ok  = frame_ok_q;
  assign err_nosop = err_nosop_q;
  assign err_len   = err_len_q;
  assign err_sop   = err_sop_q;
  assign frame_cnt = frame_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dft_stream_rx.sv
// tb_dft_stream_rx -- directed bench for dft_stream_rx with its default
// parameters. Inputs change 1 time unit after a rising edge. Outputs are
// sampled on the falling edge.
module tb_dft_stream_rx;
  import dft_rx_pkg::*;

  localparam int IN_W  = 30;
  localparam int OUT_W = 18;
  localparam int SHIFT = 12;
  localparam int DEPTH = 4;
  localparam int EW    = 2 + 2*OUT_W;
  localparam longint MAXV = (longint'(1) <<< (OUT_W-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (OUT_W-1));
`ifdef DFT_RX_ROUND_EN
  localparam logic [OUT_W-1:0] EXP_1FFF = 18'd2;
`else
  localparam logic [OUT_W-1:0] EXP_1FFF = 18'd1;
`endif

  logic              clk;
  logic              rst_n;
  logic              s_valid, s_sop, s_eop, s_ready;
  logic [IN_W-1:0]   s_real, s_imag;
  logic [11:0]       dftpts;
  logic              m_valid, m_sop, m_eop, m_ready;
  logic [OUT_W-1:0]  m_real, m_imag;
  logic              frame_ok, err_nosop, err_len, err_sop;
  logic [15:0]       frame_cnt;
  rx_state_e         dbg_state;

  dft_stream_rx #(
    .IN_W (IN_W), .OUT_W (OUT_W), .SHIFT (SHIFT), .DEPTH (DEPTH)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .s_valid (s_valid), .s_sop (s_sop), .s_eop (s_eop),
    .s_real (s_real), .s_imag (s_imag), .s_ready (s_ready),
    .dftpts (dftpts),
    .m_valid (m_valid), .m_sop (m_sop), .m_eop (m_eop),
    .m_real (m_real), .m_imag (m_imag), .m_ready (m_ready),
    .frame_ok (frame_ok), .err_nosop (err_nosop), .err_len (err_len), .err_sop (err_sop),
    .frame_cnt (frame_cnt), .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_ok = 0, n_nosop = 0, n_len = 0, n_sop = 0, n_acc = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] sb_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference narrowing model: floor shift, then clamp.
  function automatic logic [OUT_W-1:0] ref_narrow(input logic [IN_W-1:0] s);
    longint v;
    v = longint'($signed(s));
`ifdef DFT_RX_ROUND_EN
    v = v + (longint'(1) <<< (SHIFT-1));
`endif
    v = v >>> SHIFT;
    if (v > MAXV) v = MAXV;
    if (v < MINV) v = MINV;
    return v[OUT_W-1:0];
  endfunction

  function automatic logic [IN_W-1:0] smp(input int k);
    return IN_W'(k * 4096 + 37);
  endfunction

  // Pulse counters: each high cycle counts as one event.
  always @(negedge clk) begin
    if (frame_ok)  n_ok++;
    if (err_nosop) n_nosop++;
    if (err_len)   n_len++;
    if (err_sop)   n_sop++;
  end

  // Scoreboard: every beat that leaves must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL sb_extra: observed beat=0x%0h expected none", {m_sop, m_eop, m_real, m_imag});
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_beat", {m_sop, m_eop, m_real, m_imag}, sb_exp);
      end
    end
  end

  // Driver tasks.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic sop, input logic eop, input logic [IN_W-1:0] re,
                      input logic [IN_W-1:0] im, input logic push, input logic exp_eop);
    int t;
    logic rdy;
    s_valid = 1'b1; s_sop = sop; s_eop = eop; s_real = re; s_imag = im;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!s_ready && t < 500);
    rdy = s_ready;
    check("accept_timeout", rdy, 1'b1);
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    if (rdy) begin
      n_acc++;
      if (push) exp_q.push_back({sop, exp_eop, ref_narrow(re), ref_narrow(im)});
    end
  endtask

  task automatic good_frame(input int n, input int base);
    for (int i = 0; i < n; i++)
      beat(i == 0, i == n - 1, smp(base + i), smp(-base - i), 1'b1, i == n - 1);
  endtask

  int snap_len, snap_nosop, snap_sop, snap_ok;

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    s_real = '0; s_imag = '0; dftpts = 12'd12; m_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_flags", {m_sop, m_eop}, 2'b00);
    check("rst_m_real", m_real, '0);
    check("rst_m_imag", m_imag, '0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_pulses", {frame_ok, err_nosop, err_len, err_sop}, 4'b0000);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rel_s_ready", s_ready, 1'b1);
    @(posedge clk); #1;

    // Narrowing on a 12-beat frame. The first beat is held so it can be inspected.
    beat(1'b1, 1'b0, 30'h0001FFF, 30'h1FFFFFFF, 1'b1, 1'b0);
    @(negedge clk);
    check("nar_m_valid", m_valid, 1'b1);
    check("nar_m_sop", m_sop, 1'b1);
    check("nar_1fff", m_real, EXP_1FFF);
    check("nar_sat_pos", m_imag, 18'd131071);
    check("nar_state", dbg_state, ST_IN_FRAME);
    @(posedge clk); #1;
    m_ready = 1'b1;
    for (int i = 1; i < 12; i++) begin
      if (i == 1)      beat(1'b0, 1'b0, 30'h20000000, 30'h3FFFFFFF, 1'b1, 1'b0);
      else if (i == 2) beat(1'b0, 1'b0, 30'h1FFFFFFF, 30'h00000FFF, 1'b1, 1'b0);
      else             beat(1'b0, i == 11, smp(i), smp(-i), 1'b1, i == 11);
    end
    idle(3);
    check("f1_ok", n_ok, 1);
    check("f1_cnt", frame_cnt, 16'd1);
    check("f1_errs", n_len + n_nosop + n_sop, 0);
    check("f1_drained", exp_q.size(), 0);
    check("f1_state", dbg_state, ST_IDLE);

    // Early eop on beat 20 of a 24-point frame, then a complete frame of 24.
    dftpts = 12'd24;
    for (int i = 0; i < 20; i++)
      beat(i == 0, i == 19, smp(100 + i), smp(-100 - i), 1'b1, i == 19);
    idle(3);
    check("short_err_len", n_len, 1);
    check("short_cnt", frame_cnt, 16'd1);
    check("short_ok", n_ok, 1);
    good_frame(24, 200);
    idle(3);
    check("f24_ok", n_ok, 2);
    check("f24_cnt", frame_cnt, 16'd2);
    check("f24_err_len", n_len, 1);

    // Missing eop: beat 12 gets a forced eop, and the two overrun beats are dropped.
    dftpts = 12'd12;
    for (int i = 0; i < 14; i++)
      beat(i == 0, 1'b0, smp(300 + i), smp(-300 - i), i < 12, i == 11);
    idle(3);
    check("long_err_len", n_len, 2);
    check("long_nosop", n_nosop, 2);
    check("long_cnt", frame_cnt, 16'd2);
    check("long_drained", exp_q.size(), 0);

    // Beat without sop while idle, then a sop at index 5 that restarts the frame.
    beat(1'b0, 1'b0, smp(5), smp(5), 1'b0, 1'b0);
    idle(2);
    check("nosop_pulse", n_nosop, 3);
    check("nosop_no_out", m_valid, 1'b0);
    for (int i = 0; i < 5; i++)
      beat(i == 0, 1'b0, smp(400 + i), smp(-400 - i), 1'b1, 1'b0);
    good_frame(12, 500);
    idle(3);
    check("resop_err_sop", n_sop, 1);
    check("resop_ok", n_ok, 3);
    check("resop_cnt", frame_cnt, 16'd3);
    check("resop_err_len", n_len, 2);

    // Backpressure: the FIFO fills after DEPTH beats and drains in order on release.
    m_ready = 1'b0;
    n_acc = 0;
    fork
      good_frame(12, 600);
      begin
        repeat (10) @(posedge clk);
        #2;
        check("bp_s_ready", s_ready, 1'b0);
        check("bp_accepted", n_acc, DEPTH);
        check("bp_m_valid", m_valid, 1'b1);
        m_ready = 1'b1;
      end
    join
    idle(5);
    check("bp_ok", n_ok, 4);
    check("bp_cnt", frame_cnt, 16'd4);
    check("bp_drained", exp_q.size(), 0);

    // One-cycle reset at index 6 while beats are queued in the FIFO.
    for (int i = 0; i < 7; i++) begin
      if (i == 4) m_ready = 1'b0;
      beat(i == 0, 1'b0, smp(700 + i), smp(-700 - i), 1'b1, 1'b0);
    end
    snap_len = n_len; snap_nosop = n_nosop; snap_sop = n_sop; snap_ok = n_ok;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_m_valid", m_valid, 1'b0);
    check("mrst_state", dbg_state, ST_IDLE);
    check("mrst_cnt", frame_cnt, 16'd0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    idle(3);
    check("mrst_no_pulses", {n_len - snap_len, n_nosop - snap_nosop, n_sop - snap_sop, n_ok - snap_ok}, '0);
    good_frame(12, 800);
    idle(3);
    check("mrst_ok", n_ok, snap_ok + 1);
    check("mrst_cnt_after", frame_cnt, 16'd1);
    check("mrst_pulses_after", n_len + n_nosop + n_sop, snap_len + snap_nosop + snap_sop);
    check("final_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
